// File: rtl/spi_dac_player.sv
// spi_dac_player
//   Parses host-to-FPGA frames (FLAG, len_lo, len_hi, payload) arriving
//   byte-wise from the SPI socket. The payload is buffered in on-chip RAM
//   and then played out once to a parallel 8-bit DAC at clk/DIV.
//
// Ports
//   clk        system clock, all logic on posedge
//   resetn     asynchronous active-low reset
//   rxd_data   received byte, valid while rxd_flag = 1
//   rxd_flag   one-cycle strobe per received byte
//   dac_clk    DAC sample clock; DAC latches dac_data on its rising edge
//   dac_data   DAC sample, changes only with the dac_clk falling edge
//   busy       high while loading or playing a frame
//   frame_err  one-cycle pulse when a frame length is rejected
module spi_dac_player #(
   parameter int         DEPTH  = 1024,
   parameter int         ADDR_W = 10,
   parameter int         DIV    = 4,
   parameter logic [7:0] FLAG   = 8'h5A
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] rxd_data,
   input  logic       rxd_flag,
   output logic       dac_clk,
   output logic [7:0] dac_data,
   output logic       busy,
   output logic       frame_err
);

   // Sample/byte counter is one bit wider than the address so len == DEPTH fits.
   localparam int CW    = ADDR_W + 1;
   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] HALF    = DIV_W'(DIV / 2);
   localparam logic [16:0]      DEPTH17 = 17'(DEPTH);

   typedef enum logic [2:0] {IDLE, LEN_LB, LEN_HB, LOAD, PLAY} state_t;

   state_t            state;
   logic [7:0]        len_lo;
   logic [CW-1:0]     len_q;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [DIV_W-1:0]  div_cnt;
   logic              prime;
   logic [7:0]        rd_q;
   logic [7:0]        mem [DEPTH];

   logic [15:0]       len_full;
   logic [CW-1:0]     cnt_inc;
   logic [DIV_W-1:0]  div_inc;

   assign len_full = {rxd_data, len_lo};
   assign cnt_inc  = cnt + 1'b1;
   assign div_inc  = div_cnt + 1'b1;

   // Payload buffer: one write port (LOAD), one registered read port.
   always_ff @(posedge clk) begin
      if (state == LOAD && rxd_flag)
         mem[wr_ptr] <= rxd_data;
      rd_q <= mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         len_lo    <= '0;
         len_q     <= '0;
         cnt       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         div_cnt   <= '0;
         prime     <= 1'b0;
         dac_clk   <= 1'b0;
         dac_data  <= 8'h00;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rxd_flag && rxd_data == FLAG)
                  state <= LEN_LB;
            end
            LEN_LB: begin
               if (rxd_flag) begin
                  len_lo <= rxd_data;
                  state  <= LEN_HB;
               end
            end
            LEN_HB: begin
               if (rxd_flag) begin
                  if (len_full == '0 || {1'b0, len_full} > DEPTH17) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     len_q  <= len_full[CW-1:0];
                     wr_ptr <= '0;
                     cnt    <= '0;
                     busy   <= 1'b1;
                     state  <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (rxd_flag) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  cnt    <= cnt_inc;
                  if (cnt_inc == len_q) begin
                     // Last byte: rewind for playback; the first PLAY cycle
                     // only issues the read of mem[0].
                     state   <= PLAY;
                     cnt     <= '0;
                     rd_ptr  <= '0;
                     div_cnt <= '0;
                     prime   <= 1'b1;
                  end
               end
            end
            PLAY: begin
               if (prime) begin
                  prime <= 1'b0;
               end else if (cnt == '0 || div_cnt == DIV_MAX) begin
                  // First sample loads as soon as rd_q holds mem[0]; later
                  // ones load on the div_cnt wrap (dac_clk falling edge).
                  if (cnt == len_q) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     dac_clk <= 1'b0;
                     div_cnt <= '0;
                  end else begin
                     dac_data <= rd_q;
                     rd_ptr   <= rd_ptr + 1'b1;
                     cnt      <= cnt_inc;
                     div_cnt  <= '0;
                     dac_clk  <= 1'b0;
                  end
               end else begin
                  div_cnt <= div_inc;
                  dac_clk <= (div_inc >= HALF);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_dac_player.sv
// Directed bench for spi_dac_player: frames are driven byte-wise, a monitor
// records every dac_clk rising edge (sample value and clk cycle) and
// frame_err activity, and results are compared against hand-computed values.
module tb_spi_dac_player;

   logic       clk;
   logic       resetn;
   logic [7:0] rxd_data;
   logic       rxd_flag;
   logic       dac_clk;
   logic [7:0] dac_data;
   logic       busy;
   logic       frame_err;

   int checks;
   int fails;

   spi_dac_player #(.DEPTH(1024), .ADDR_W(10), .DIV(4), .FLAG(8'h5A)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rxd_data  (rxd_data),
      .rxd_flag  (rxd_flag),
      .dac_clk   (dac_clk),
      .dac_data  (dac_data),
      .busy      (busy),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor state, written only here.
   int         cyc;
   logic [7:0] smp[$];
   int         edge_cyc[$];
   int         hi_cnt;
   int         stab_err;
   int         err_cycles;
   int         err_pulses;
   logic       prev_dclk;
   logic       prev_err;
   logic [7:0] hold;

   initial begin
      cyc = 0; hi_cnt = 0; stab_err = 0; err_cycles = 0; err_pulses = 0;
      prev_dclk = 1'b0; prev_err = 1'b0; hold = 8'h00;
   end

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (dac_clk && !prev_dclk) begin
         smp.push_back(dac_data);
         edge_cyc.push_back(cyc);
      end
      if (dac_clk) begin
         if (prev_dclk && dac_data != hold) stab_err++;
         hold = dac_data;
         hi_cnt++;
      end
      if (frame_err) begin
         err_cycles++;
         if (!prev_err) err_pulses++;
      end
      prev_dclk = dac_clk;
      prev_err  = frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rxd_data = b;
      rxd_flag = 1'b1;
      @(negedge clk);
      rxd_flag = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n;
      n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   int b, h, ep, ec, mism;

   initial begin
      checks = 0; fails = 0;
      rxd_data = 8'h00; rxd_flag = 1'b0; resetn = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("rst_dac_clk",  {31'd0, dac_clk},   32'd0);
      chk("rst_dac_data", {24'd0, dac_data},  32'd0);
      chk("rst_busy",     {31'd0, busy},      32'd0);
      chk("rst_frame_err",{31'd0, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // 1) basic 4-sample frame
      b = smp.size(); h = hi_cnt;
      send(8'h5A); send(8'h04); send(8'h00);
      send(8'h11);
      chk("t1_busy_load", {31'd0, busy}, 32'd1);
      send(8'h22); send(8'h33); send(8'h44);
      @(negedge clk);
      chk("t1_first_latency", {24'd0, dac_data}, 32'h11);
      chk("t1_busy_play", {31'd0, busy}, 32'd1);
      wait_idle("t1_idle_timeout", 100);
      chk("t1_count", smp.size() - b, 32'd4);
      chk("t1_s0", {24'd0, smp[b]},   32'h11);
      chk("t1_s1", {24'd0, smp[b+1]}, 32'h22);
      chk("t1_s2", {24'd0, smp[b+2]}, 32'h33);
      chk("t1_s3", {24'd0, smp[b+3]}, 32'h44);
      chk("t1_period01", edge_cyc[b+1] - edge_cyc[b],   32'd4);
      chk("t1_period23", edge_cyc[b+3] - edge_cyc[b+2], 32'd4);
      chk("t1_high_cycles", hi_cnt - h, 32'd8);
      repeat (6) @(negedge clk);
      chk("t1_hold_data", {24'd0, dac_data}, 32'h44);
      chk("t1_clk_low",   {31'd0, dac_clk},  32'd0);
      chk("t1_no_extra",  smp.size() - b,    32'd4);

      // 2) junk before flag is discarded
      b = smp.size();
      send(8'hAA); send(8'h00);
      send(8'h5A); send(8'h02); send(8'h00); send(8'h7F); send(8'h80);
      wait_idle("t2_idle_timeout", 100);
      chk("t2_count", smp.size() - b, 32'd2);
      chk("t2_s0", {24'd0, smp[b]},   32'h7F);
      chk("t2_s1", {24'd0, smp[b+1]}, 32'h80);

      // 3) rejected lengths: 0 and DEPTH+1
      b = smp.size(); ep = err_pulses; ec = err_cycles;
      send(8'h5A); send(8'h00); send(8'h00);
      chk("t3_err_len0", err_pulses - ep, 32'd1);
      send(8'h5A); send(8'h01); send(8'h04);
      repeat (3) @(negedge clk);
      chk("t3_err_pulses", err_pulses - ep, 32'd2);
      chk("t3_err_cycles", err_cycles - ec, 32'd2);
      chk("t3_no_samples", smp.size() - b,  32'd0);
      chk("t3_busy",       {31'd0, busy},   32'd0);

      // 4) len == DEPTH, payload i mod 256
      b = smp.size();
      send(8'h5A); send(8'h00); send(8'h04);
      for (int i = 0; i < 1024; i++) send(8'(i));
      wait_idle("t4_idle_timeout", 6000);
      chk("t4_count", smp.size() - b, 32'd1024);
      mism = 0;
      for (int i = 0; i < 1024; i++)
         if (smp[b+i] !== 8'(i)) mism++;
      chk("t4_order_mism", mism, 32'd0);
      chk("t4_s256",  {24'd0, smp[b+256]},  32'h00);
      chk("t4_s1023", {24'd0, smp[b+1023]}, 32'hFF);

      // 5) bytes during PLAY are dropped; back-to-back frame accepted
      b = smp.size(); ep = err_pulses;
      send(8'h5A); send(8'h03); send(8'h00);
      send(8'hA1); send(8'hB2); send(8'hC3);
      send(8'h5A); send(8'h01); send(8'h00); send(8'h55);
      wait_idle("t5_idle_timeout", 100);
      chk("t5_count", smp.size() - b, 32'd3);
      chk("t5_s0", {24'd0, smp[b]},   32'hA1);
      chk("t5_s2", {24'd0, smp[b+2]}, 32'hC3);
      chk("t5_no_err", err_pulses - ep, 32'd0);
      b = smp.size();
      send(8'h5A); send(8'h01); send(8'h00); send(8'h55);
      wait_idle("t5b_idle_timeout", 100);
      chk("t5b_count", smp.size() - b, 32'd1);
      chk("t5b_s0", {24'd0, smp[b]}, 32'h55);

      // 6) reset mid-LOAD, then a fresh 1-byte frame
      send(8'h5A); send(8'h04); send(8'h00); send(8'h01); send(8'h02);
      chk("t6_busy_before", {31'd0, busy}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_busy", {31'd0, busy},     32'd0);
      chk("t6_rst_data", {24'd0, dac_data}, 32'd0);
      chk("t6_rst_clk",  {31'd0, dac_clk},  32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      b = smp.size();
      send(8'h5A); send(8'h01); send(8'h00); send(8'h99);
      wait_idle("t6_idle_timeout", 100);
      chk("t6_count", smp.size() - b, 32'd1);
      chk("t6_s0", {24'd0, smp[b]}, 32'h99);
      chk("t6_hold", {24'd0, dac_data}, 32'h99);

      chk("stable_high_phase", stab_err, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
